ex_mem_stage: RTL and testbench

- EX/MEM pipeline stage directly downstream of the ALU in the pipelined MIPS core.
- Registers the ALU result, zero flag, store data and destination/control bits for the memory stage.
- Resolves beq/bne from the ALU zero flag and issues a one-cycle PC redirect.
- Provides MEM-stage forwarding qualifiers to the hazard unit.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ex_mem_stage_if.sv | 53 +++++
 rtl/ex_mem_stage_branch_resolve.sv | 39 +++
 rtl/ex_mem_stage.sv | 102 ++++++++++
 tb/tb_ex_mem_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: datapath widths, exception
// vector, MEM-stage control bundle and branch-type encoding.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0180;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
    } mem_ctl_t;

    // {bne, beq}; both set is malformed and never redirects
    typedef enum logic [1:0] {
        BR_NONE    = 2'b00,
        BR_EQ      = 2'b01,
        BR_NE      = 2'b10,
        BR_INVALID = 2'b11
    } br_type_e;

    function automatic br_type_e br_decode(input logic beq, input logic bne);
        return br_type_e'({bne, beq});
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX -> MEM stage bus. Optional OVERFLOW_TRAP_EN adds ex_ovf / mem_exc.
interface ex_mem_stage_if;
    import cpu_pkg::*;

    logic            ex_valid;
    logic [XLEN-1:0] ex_alu_out;
    logic            ex_alu_z;
    logic [XLEN-1:0] ex_store_data;
    logic [REGW-1:0] ex_wreg;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_beq;
    logic            ex_bne;
    logic [XLEN-1:0] ex_br_target;
`ifdef OVERFLOW_TRAP_EN
    logic            ex_ovf;
    logic            mem_exc;
`endif
    logic            mem_valid;
    logic [XLEN-1:0] mem_alu_out;
    logic [XLEN-1:0] mem_store_data;
    logic [REGW-1:0] mem_wreg;
    logic            mem_regwrite;
    logic            mem_memread;
    logic            mem_memwrite;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            fwd_valid;

    modport master (
        output ex_valid, ex_alu_out, ex_alu_z, ex_store_data, ex_wreg,
               ex_regwrite, ex_memread, ex_memwrite, ex_beq, ex_bne, ex_br_target,
`ifdef OVERFLOW_TRAP_EN
        output ex_ovf,
        input  mem_exc,
`endif
        input  mem_valid, mem_alu_out, mem_store_data, mem_wreg, mem_regwrite,
               mem_memread, mem_memwrite, pc_src, pc_target, fwd_valid
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_alu_z, ex_store_data, ex_wreg,
               ex_regwrite, ex_memread, ex_memwrite, ex_beq, ex_bne, ex_br_target,
`ifdef OVERFLOW_TRAP_EN
        input  ex_ovf,
        output mem_exc,
`endif
        output mem_valid, mem_alu_out, mem_store_data, mem_wreg, mem_regwrite,
               mem_memread, mem_memwrite, pc_src, pc_target, fwd_valid
    );

endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// Combinational branch resolution from the ALU zero flag; with OVERFLOW_TRAP_EN
// an overflow trap overrides the branch and redirects to EXC_VECTOR.
module branch_resolve
    import cpu_pkg::*;
(
    input  logic            valid,
    input  logic            beq,
    input  logic            bne,
    input  logic            z,
    input  logic [XLEN-1:0] br_target,
`ifdef OVERFLOW_TRAP_EN
    input  logic            exc,
`endif
    output logic            redirect,
    output logic [XLEN-1:0] target
);

    br_type_e br_type;
    logic     taken;

    always_comb begin
        br_type = br_decode(beq, bne);
        taken   = 1'b0;
        unique case (br_type)
            BR_EQ:   taken = valid & z;
            BR_NE:   taken = valid & ~z;
            default: taken = 1'b0;
        endcase
    end

`ifdef OVERFLOW_TRAP_EN
    assign redirect = taken | exc;
    assign target   = exc ? EXC_VECTOR : br_target;
`else
    assign redirect = taken;
    assign target   = br_target;
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the ALU result and MEM controls, issues a
// one-cycle PC redirect for taken branches. Optional feature: OVERFLOW_TRAP_EN.
module ex_mem_stage
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic flush,
    ex_mem_stage_if.slave bus
);

    logic            mem_valid_q;
    mem_ctl_t        ctl_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] store_q;
    logic [REGW-1:0] wreg_q;
    logic            pc_src_q;
    logic [XLEN-1:0] pc_target_q;
    logic            exc_q;

    logic            trap;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    mem_ctl_t        cap_ctl;

`ifdef OVERFLOW_TRAP_EN
    assign trap = bus.ex_valid & bus.ex_ovf;
`else
    assign trap = 1'b0;
`endif

    branch_resolve u_branch (
        .valid     (bus.ex_valid),
        .beq       (bus.ex_beq),
        .bne       (bus.ex_bne),
        .z         (bus.ex_alu_z),
        .br_target (bus.ex_br_target),
`ifdef OVERFLOW_TRAP_EN
        .exc       (trap),
`endif
        .redirect  (redirect),
        .target    (redirect_target)
    );

    // A trapping instruction must not touch the register file or memory;
    // writes to r0 are dropped here so forwarding never sees them.
    always_comb begin
        cap_ctl.regwrite = bus.ex_valid & bus.ex_regwrite & (bus.ex_wreg != '0) & ~trap;
        cap_ctl.memread  = bus.ex_valid & bus.ex_memread & ~trap;
        cap_ctl.memwrite = bus.ex_valid & bus.ex_memwrite & ~trap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            ctl_q       <= '0;
            alu_q       <= '0;
            store_q     <= '0;
            wreg_q      <= '0;
            pc_src_q    <= 1'b0;
            pc_target_q <= '0;
            exc_q       <= 1'b0;
        end else if (flush) begin
            mem_valid_q <= 1'b0;
            ctl_q       <= '0;
            pc_src_q    <= 1'b0;
            exc_q       <= 1'b0;
        end else if (stall) begin
            // redirect already went out; repeating it would re-squash the front end
            pc_src_q    <= 1'b0;
        end else begin
            mem_valid_q <= bus.ex_valid;
            ctl_q       <= cap_ctl;
            alu_q       <= bus.ex_alu_out;
            store_q     <= bus.ex_store_data;
            wreg_q      <= bus.ex_wreg;
            pc_src_q    <= redirect;
            pc_target_q <= redirect_target;
            exc_q       <= trap;
        end
    end

    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_alu_out    = alu_q;
    assign bus.mem_store_data = store_q;
    assign bus.mem_wreg       = wreg_q;
    assign bus.mem_regwrite   = ctl_q.regwrite;
    assign bus.mem_memread    = ctl_q.memread;
    assign bus.mem_memwrite   = ctl_q.memwrite;
    assign bus.pc_src         = pc_src_q;
    assign bus.pc_target      = pc_target_q;
    // load data only arrives at the end of MEM, so loads are not forwardable yet
    assign bus.fwd_valid      = mem_valid_q & ctl_q.regwrite & ~ctl_q.memread;
`ifdef OVERFLOW_TRAP_EN
    assign bus.mem_exc        = exc_q;
`else
    logic unused_exc;
    assign unused_exc = exc_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: an instruction-level model checked every
// negedge, plus hand-computed literal checks. Honours OVERFLOW_TRAP_EN.
module tb_ex_mem_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the instruction sitting in MEM, plus the pending redirect
    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  wreg;
        logic        rw;
        logic        ld;
        logic        st;
        logic        exc;
    } minstr_t;

    minstr_t     m;
    logic        m_redirect;
    logic [31:0] m_target;
    logic        trap_in;
    logic        is_taken;

    always_comb begin
`ifdef OVERFLOW_TRAP_EN
        trap_in = bus.ex_valid && bus.ex_ovf;
`else
        trap_in = 1'b0;
`endif
        is_taken = 1'b0;
        if (bus.ex_valid && (bus.ex_beq != bus.ex_bne))
            is_taken = bus.ex_beq ? bus.ex_alu_z : !bus.ex_alu_z;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m          <= '{valid: 1'b0, addr: 32'h0, sdata: 32'h0, wreg: 5'h0,
                            rw: 1'b0, ld: 1'b0, st: 1'b0, exc: 1'b0};
            m_redirect <= 1'b0;
            m_target   <= 32'h0;
        end else if (flush) begin
            m.valid    <= 1'b0;
            m.rw       <= 1'b0;
            m.ld       <= 1'b0;
            m.st       <= 1'b0;
            m.exc      <= 1'b0;
            m_redirect <= 1'b0;
        end else if (stall) begin
            m_redirect <= 1'b0;
        end else begin
            m.valid    <= bus.ex_valid;
            m.addr     <= bus.ex_alu_out;
            m.sdata    <= bus.ex_store_data;
            m.wreg     <= bus.ex_wreg;
            m.rw       <= bus.ex_valid && bus.ex_regwrite && bus.ex_wreg != 5'd0 && !trap_in;
            m.ld       <= bus.ex_valid && bus.ex_memread && !trap_in;
            m.st       <= bus.ex_valid && bus.ex_memwrite && !trap_in;
            m.exc      <= trap_in;
            m_redirect <= trap_in || is_taken;
            m_target   <= trap_in ? 32'h8000_0180 : bus.ex_br_target;
        end
    end

    always @(negedge clk) begin
        check("mem_valid", {31'b0, bus.mem_valid}, {31'b0, m.valid});
        check("mem_alu_out", bus.mem_alu_out, m.addr);
        check("mem_store_data", bus.mem_store_data, m.sdata);
        check("mem_wreg", {27'b0, bus.mem_wreg}, {27'b0, m.wreg});
        check("mem_regwrite", {31'b0, bus.mem_regwrite}, {31'b0, m.rw});
        check("mem_memread", {31'b0, bus.mem_memread}, {31'b0, m.ld});
        check("mem_memwrite", {31'b0, bus.mem_memwrite}, {31'b0, m.st});
        check("pc_src", {31'b0, bus.pc_src}, {31'b0, m_redirect});
        check("fwd_valid", {31'b0, bus.fwd_valid}, {31'b0, m.valid && m.rw && !m.ld});
        if (m_redirect) check("pc_target", bus.pc_target, m_target);
`ifdef OVERFLOW_TRAP_EN
        check("mem_exc", {31'b0, bus.mem_exc}, {31'b0, m.exc});
`endif
    end

    task automatic drive(input logic v, input logic [31:0] alu, input logic z,
                         input logic [31:0] sd, input logic [4:0] wr,
                         input logic rw, input logic rd, input logic wm,
                         input logic beq, input logic bne, input logic [31:0] tgt);
        bus.ex_valid      = v;
        bus.ex_alu_out    = alu;
        bus.ex_alu_z      = z;
        bus.ex_store_data = sd;
        bus.ex_wreg       = wr;
        bus.ex_regwrite   = rw;
        bus.ex_memread    = rd;
        bus.ex_memwrite   = wm;
        bus.ex_beq        = beq;
        bus.ex_bne        = bne;
        bus.ex_br_target  = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
`ifdef OVERFLOW_TRAP_EN
        bus.ex_ovf = 1'b0;
`endif
        nop();
        nop();
        check("reset mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        check("reset pc_src", {31'b0, bus.pc_src}, 32'h0);
        check("reset mem_alu_out", bus.mem_alu_out, 32'h0);
        rst_n = 1'b1;

        // add r5 = 0x1234
        drive(1, 32'h0000_1234, 0, 32'h0, 5'd5, 1, 0, 0, 0, 0, 32'h0);
        check("add alu_out", bus.mem_alu_out, 32'h0000_1234);
        check("add fwd_valid", {31'b0, bus.fwd_valid}, 32'h1);
        // write to r0 is dropped
        drive(1, 32'h0000_AAAA, 0, 32'h0, 5'd0, 1, 0, 0, 0, 0, 32'h0);
        check("r0 regwrite", {31'b0, bus.mem_regwrite}, 32'h0);
        check("r0 fwd_valid", {31'b0, bus.fwd_valid}, 32'h0);
        // lw r5
        drive(1, 32'h1000_0040, 0, 32'h0, 5'd5, 1, 1, 0, 0, 0, 32'h0);
        check("lw memread", {31'b0, bus.mem_memread}, 32'h1);
        check("lw fwd_valid", {31'b0, bus.fwd_valid}, 32'h0);
        // sw
        drive(1, 32'h1000_0044, 0, 32'hDEAD_BEEF, 5'd0, 0, 0, 1, 0, 0, 32'h0);
        check("sw memwrite", {31'b0, bus.mem_memwrite}, 32'h1);
        check("sw store_data", bus.mem_store_data, 32'hDEAD_BEEF);

        // beq taken
        drive(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'h0040_0020);
        check("beq pc_src", {31'b0, bus.pc_src}, 32'h1);
        check("beq pc_target", bus.pc_target, 32'h0040_0020);
        nop();
        check("beq pc_src drop", {31'b0, bus.pc_src}, 32'h0);
        // bne with z=1 not taken
        drive(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h0040_0020);
        check("bne nt pc_src", {31'b0, bus.pc_src}, 32'h0);
        // bne with z=0 taken
        drive(1, 32'h5, 0, 32'h0, 5'd0, 0, 0, 0, 0, 1, 32'h0040_0100);
        check("bne pc_target", bus.pc_target, 32'h0040_0100);
        // beq & bne together: not a branch
        drive(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 1, 1, 32'h0040_0200);
        check("beq+bne pc_src", {31'b0, bus.pc_src}, 32'h0);
        drive(1, 32'h1, 0, 32'h0, 5'd0, 0, 0, 0, 1, 1, 32'h0040_0200);
        // bubble with beq set never redirects
        drive(0, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'h0040_0300);
        check("invalid beq pc_src", {31'b0, bus.pc_src}, 32'h0);

        // taken branch then 3 stall cycles
        drive(1, 32'h0000_0055, 1, 32'h0, 5'd7, 1, 0, 0, 1, 0, 32'h0040_0400);
        check("stall br pc_src", {31'b0, bus.pc_src}, 32'h1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_0099, 0, 32'h11, 5'd9, 1, 0, 0, 1, 0, 32'h0040_0500);
            check("stall pc_src", {31'b0, bus.pc_src}, 32'h0);
            check("stall alu_out", bus.mem_alu_out, 32'h0000_0055);
        end
        // flush wins over stall; data registers hold
        flush = 1'b1;
        drive(1, 32'h0000_0077, 0, 32'h0, 5'd3, 1, 0, 0, 0, 0, 32'h0);
        check("flush mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        check("flush regwrite", {31'b0, bus.mem_regwrite}, 32'h0);
        check("flush alu_out hold", bus.mem_alu_out, 32'h0000_0055);
        stall = 1'b0;
        // flushed taken branch must not redirect
        drive(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'h0040_0600);
        check("flush br pc_src", {31'b0, bus.pc_src}, 32'h0);
        flush = 1'b0;
        nop();

        // asynchronous reset mid-cycle
        drive(1, 32'h0000_1234, 1, 32'h0, 5'd5, 1, 0, 0, 1, 0, 32'h0040_0700);
        check("pre-reset mem_valid", {31'b0, bus.mem_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        check("async rst pc_src", {31'b0, bus.pc_src}, 32'h0);
        check("async rst alu_out", bus.mem_alu_out, 32'h0);
        check("async rst fwd_valid", {31'b0, bus.fwd_valid}, 32'h0);
        nop();
        rst_n = 1'b1;
        nop();

`ifdef OVERFLOW_TRAP_EN
        bus.ex_ovf = 1'b1;
        drive(1, 32'h8000_0000, 0, 32'h0, 5'd4, 1, 0, 0, 0, 0, 32'h0);
        check("ovf mem_exc", {31'b0, bus.mem_exc}, 32'h1);
        check("ovf regwrite", {31'b0, bus.mem_regwrite}, 32'h0);
        check("ovf pc_src", {31'b0, bus.pc_src}, 32'h1);
        check("ovf pc_target", bus.pc_target, 32'h8000_0180);
        // trap beats a simultaneous taken branch
        drive(1, 32'h0, 1, 32'h0, 5'd4, 1, 0, 0, 1, 0, 32'h0040_0800);
        check("ovf+br pc_target", bus.pc_target, 32'h8000_0180);
        bus.ex_ovf = 1'b0;
        nop();
        check("ovf clear mem_exc", {31'b0, bus.mem_exc}, 32'h0);
`endif
        nop();
        nop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
